// File: rtl/bus_arbiter_8.sv
// Round-robin arbiter for an 8-source bus, with one dead cycle between owners.
// Optional owner pre-emption after MAX_HOLD cycles is enabled by defining ARB_TIMEOUT_EN.
module bus_arbiter_8 #(
   parameter int MAX_HOLD = 16,
   parameter int CNT_W    = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] req,
   output logic [2:0] sel,
   output logic       bus_en,
   output logic [7:0] gnt,
   output logic       preempt
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      GRANT    = 2'd1,
      HANDOVER = 2'd2
   } state_t;

   if (MAX_HOLD < 2 || MAX_HOLD > 2**CNT_W) begin : g_bad_cfg
      $error("bus_arbiter_8: MAX_HOLD must be in 2..2**CNT_W");
   end

   state_t     state_q, state_d;
   logic [2:0] sel_q, sel_d;
   logic       bus_en_q, bus_en_d;
   logic [7:0] gnt_q, gnt_d;
   logic [2:0] last_q, last_d;

   logic       rr_found;
   logic [2:0] rr_idx;

`ifdef ARB_TIMEOUT_EN
   localparam logic [CNT_W-1:0] HOLD_LIMIT = CNT_W'(MAX_HOLD - 1);

   logic             preempt_q, preempt_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [7:0]       others_req;
`endif

   // Scan from last+1 upward; k==8 wraps back to last itself, so it has lowest priority.
   always_comb begin
      rr_found = 1'b0;
      rr_idx   = last_q;
      for (int unsigned k = 1; k <= 8; k++) begin
         logic [2:0] idx;
         idx = last_q + 3'(k);
         if (!rr_found && req[idx]) begin
            rr_found = 1'b1;
            rr_idx   = idx;
         end
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_comb begin
      others_req = req & ~(8'b1 << sel_q);
   end
`endif

   always_comb begin
      state_d  = state_q;
      sel_d    = sel_q;
      bus_en_d = bus_en_q;
      gnt_d    = gnt_q;
      last_d   = last_q;
`ifdef ARB_TIMEOUT_EN
      preempt_d  = 1'b0;
      hold_cnt_d = hold_cnt_q;
`endif
      case (state_q)
         IDLE, HANDOVER: begin
            bus_en_d = 1'b0;
            gnt_d    = '0;
            state_d  = IDLE;
            if (rr_found) begin
               state_d  = GRANT;
               sel_d    = rr_idx;
               bus_en_d = 1'b1;
               gnt_d    = 8'b1 << rr_idx;
               last_d   = rr_idx;
`ifdef ARB_TIMEOUT_EN
               hold_cnt_d = '0;
`endif
            end
         end
         GRANT: begin
            if (!req[sel_q]) begin
               state_d  = HANDOVER;
               bus_en_d = 1'b0;
               gnt_d    = '0;
            end
`ifdef ARB_TIMEOUT_EN
            // last keeps the pre-empted owner, pushing it to the back of the RR order.
            else if (hold_cnt_q == HOLD_LIMIT && others_req != '0) begin
               state_d   = HANDOVER;
               bus_en_d  = 1'b0;
               gnt_d     = '0;
               preempt_d = 1'b1;
            end else if (hold_cnt_q != '1) begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
`endif
         end
         default: begin
            state_d  = IDLE;
            bus_en_d = 1'b0;
            gnt_d    = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         sel_q    <= '0;
         bus_en_q <= 1'b0;
         gnt_q    <= '0;
         last_q   <= 3'd7;
      end else begin
         state_q  <= state_d;
         sel_q    <= sel_d;
         bus_en_q <= bus_en_d;
         gnt_q    <= gnt_d;
         last_q   <= last_d;
      end
   end

`ifdef ARB_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         preempt_q  <= 1'b0;
         hold_cnt_q <= '0;
      end else begin
         preempt_q  <= preempt_d;
         hold_cnt_q <= hold_cnt_d;
      end
   end

   assign preempt = preempt_q;
`else
   assign preempt = 1'b0;
`endif

   assign sel    = sel_q;
   assign bus_en = bus_en_q;
   assign gnt    = gnt_q;

endmodule

// File: tb/tb_bus_arbiter_8.sv
// Directed, table-driven bench for bus_arbiter_8 (MAX_HOLD overridden to 4).
module tb_bus_arbiter_8;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] req;
   logic [2:0] sel;
   logic       bus_en;
   logic [7:0] gnt;
   logic       preempt;

   int errors = 0;
   int checks = 0;

   bus_arbiter_8 #(.MAX_HOLD(4), .CNT_W(5)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .sel     (sel),
      .bus_en  (bus_en),
      .gnt     (gnt),
      .preempt (preempt)
   );

   always #5 clk = ~clk;

   typedef struct {
      string      name;
      logic       rst;
      logic [7:0] req;
      logic [2:0] sel;
      logic       en;
      logic [7:0] gnt;
      logic       pre;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(string n, logic r, logic [7:0] q, logic [2:0] s,
                               logic e, logic [7:0] g, logic p);
      vec_t v;
      v.name = n; v.rst = r; v.req = q; v.sel = s; v.en = e; v.gnt = g; v.pre = p;
      vecs.push_back(v);
   endfunction

   task automatic check(string n, logic [2:0] s, logic e, logic [7:0] g, logic p);
      checks++;
      if ({sel, bus_en, gnt, preempt} !== {s, e, g, p}) begin
         errors++;
         $display("FAIL %s: got sel=%0d bus_en=%0b gnt=%02h preempt=%0b, want sel=%0d bus_en=%0b gnt=%02h preempt=%0b",
                  n, sel, bus_en, gnt, preempt, s, e, g, p);
      end
      checks++;
      if ($countones(gnt) > 1 || bus_en !== (|gnt)) begin
         errors++;
         $display("FAIL %s_invariant: got gnt=%02h bus_en=%0b, want one-hot-or-zero gnt with bus_en==|gnt",
                  n, gnt, bus_en);
      end
   endtask

   task automatic step(logic r, logic [7:0] q);
      rst = r;
      req = q;
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      req = 8'hFF;

      // reset with all requests high
      add("rst_a", 1, 8'hFF, 0, 0, 8'h00, 0);
      add("rst_b", 1, 8'hFF, 0, 0, 8'h00, 0);
      // single requester then release
      add("single_grant", 0, 8'h08, 3, 1, 8'h08, 0);
      add("single_hand",  0, 8'h00, 3, 0, 8'h00, 0);
      add("single_idle",  0, 8'h00, 3, 0, 8'h00, 0);
      add("single_idle2", 0, 8'h00, 3, 0, 8'h00, 0);
      // two sources alternating, each drops req for one cycle
      add("alt_rst", 1, 8'h00, 0, 0, 8'h00, 0);
      for (int r = 0; r < 2; r++) begin
         add("alt_g2",   0, 8'h24, 2, 1, 8'h04, 0);
         add("alt_g2",   0, 8'h24, 2, 1, 8'h04, 0);
         add("alt_g2",   0, 8'h24, 2, 1, 8'h04, 0);
         add("alt_h2",   0, 8'h20, 2, 0, 8'h00, 0);
         add("alt_g5",   0, 8'h24, 5, 1, 8'h20, 0);
         add("alt_g5",   0, 8'h24, 5, 1, 8'h20, 0);
         add("alt_g5",   0, 8'h24, 5, 1, 8'h20, 0);
         add("alt_h5",   0, 8'h04, 5, 0, 8'h00, 0);
      end
      // full rotation with all sources requesting
      add("rr_rst", 1, 8'h00, 0, 0, 8'h00, 0);
      for (int i = 0; i < 8; i++) begin
         logic [7:0] oh;
         oh = 8'h01 << i;
         add("rr_grant", 0, 8'hFF, 3'(i), 1, oh,    0);
         add("rr_hand",  0, ~oh,   3'(i), 0, 8'h00, 0);
      end
      add("rr_wrap", 0, 8'hFF, 0, 1, 8'h01, 0);
      // reset while source 6 owns the bus
      add("r6_hand",  0, 8'h40, 0, 0, 8'h00, 0);
      add("r6_grant", 0, 8'h40, 6, 1, 8'h40, 0);
      add("r6_rst",   1, 8'h40, 0, 0, 8'h00, 0);
      add("r6_after", 0, 8'h41, 0, 1, 8'h01, 0);

      foreach (vecs[i]) begin
         step(vecs[i].rst, vecs[i].req);
         check(vecs[i].name, vecs[i].sel, vecs[i].en, vecs[i].gnt, vecs[i].pre);
      end

      // hold timeout with a competing requester
      step(1, 8'h00);
      check("to_rst", 0, 0, 8'h00, 0);
      for (int c = 0; c < 4; c++) begin
         step(0, 8'h03);
         check("to_hold0", 0, 1, 8'h01, 0);
      end
`ifdef ARB_TIMEOUT_EN
      step(0, 8'h03);
      check("to_preempt", 0, 0, 8'h00, 1);
      step(0, 8'h03);
      check("to_next1", 1, 1, 8'h02, 0);
`else
      for (int c = 0; c < 8; c++) begin
         step(0, 8'h03);
         check("to_nopreempt", 0, 1, 8'h01, 0);
      end
`endif

      // sole requester is never pre-empted, across hold counter saturation
      step(1, 8'h00);
      check("sole_rst", 0, 0, 8'h00, 0);
      for (int c = 0; c < 40; c++) begin
         step(0, 8'h01);
         check("sole_hold", 0, 1, 8'h01, 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
